// File: rtl/imm_pack_unit_pkg.sv
// Shared encodings and field masks for the immediate packer.
// Masks select the instr[31:7] bit positions owned by each immediate format.
package imm_pack_unit_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [24:0] MASK_I  = 25'h1FFE000;
    localparam logic [24:0] MASK_SB = 25'h1FC001F;
    localparam logic [24:0] MASK_J  = 25'h1FFFFE0;

    function automatic logic [24:0] fmt_mask(input imm_src_e src);
        case (src)
            IMM_I:   return MASK_I;
            IMM_J:   return MASK_J;
            default: return MASK_SB;
        endcase
    endfunction

endpackage

// File: rtl/imm_pack_fmt.sv
// Combinational scatter of immediate bits into the 25-bit instr[31:7] field.
// Positions not owned by the format are left zero; the caller merges BASE there.
module imm_pack_fmt
    import imm_pack_unit_pkg::*;
(
    input  logic [1:0]  src,
    input  logic [20:0] imm,
    output logic [24:0] field
);

    always_comb begin
        field = '0;
        case (src)
            IMM_I: begin
                field[24:13] = imm[11:0];
            end
            IMM_S: begin
                field[24:18] = imm[11:5];
                field[4:0]   = imm[4:0];
            end
            IMM_B: begin
                field[24]    = imm[12];
                field[23:18] = imm[10:5];
                field[4:1]   = imm[4:1];
                field[0]     = imm[11];
            end
            IMM_J: begin
                field[24]    = imm[20];
                field[23:14] = imm[10:1];
                field[13]    = imm[11];
                field[12:5]  = imm[19:12];
            end
            default: begin
                field = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack_unit.sv
// Two-stage valid/ready immediate encoder: stage 1 captures the request and checks range/alignment,
// stage 2 holds the packed instr[31:7] field merged with the caller's template bits.
module imm_pack_unit
    import imm_pack_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IMM,
    input  logic [1:0]       IMMSRC,
    input  logic [24:0]      BASE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [24:0]      INSTR,
    output logic             RANGE_ERR,
    output logic             ALIGN_ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    logic               vld_p1;
    logic signed [31:0] imm_p1;
    imm_src_e           src_p1;
    logic [24:0]        base_p1;
    logic               adv_p1;
    logic               range_p1;
    logic               align_p1;
    logic [24:0]        field_p1;
    logic [24:0]        mask_p1;
    logic [24:0]        merged_p1;

    logic               vld_p2;
    logic [24:0]        instr_p2;
    logic               range_p2;
    logic               align_p2;
    logic [CNT_W-1:0]   err_cnt;

    // True when v[31:msb] are all copies of the same bit, i.e. v fits in msb+1 signed bits.
    function automatic logic fits_signed(input logic signed [31:0] v, input logic [4:0] msb);
        logic signed [31:0] s;
        s = v >>> msb;
        return (s == 32'sd0) || (s == -32'sd1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign adv_p1   = !vld_p2 || OUT_READY;
    assign IN_READY = !vld_p1 || adv_p1;

    // ---- stage 1: request capture ----
    always_ff @(posedge CLK) begin
        if (IN_VALID && IN_READY) begin
            imm_p1  <= $signed(IMM);
            src_p1  <= imm_src_e'(IMMSRC);
            base_p1 <= BASE;
        end
    end

    always_comb begin
        range_p1 = 1'b0;
        align_p1 = 1'b0;
        case (src_p1)
            IMM_I, IMM_S: begin
                range_p1 = !fits_signed(imm_p1, 5'd11);
            end
            IMM_B: begin
                range_p1 = !fits_signed(imm_p1, 5'd12);
                align_p1 = imm_p1[0];
            end
            IMM_J: begin
                range_p1 = !fits_signed(imm_p1, 5'd20);
                align_p1 = imm_p1[0];
            end
            default: begin
                range_p1 = 1'b0;
            end
        endcase
    end

    imm_pack_fmt u_fmt (
        .src   (src_p1),
        .imm   (imm_p1[20:0]),
        .field (field_p1)
    );

    assign mask_p1   = fmt_mask(src_p1);
    assign merged_p1 = (field_p1 & mask_p1) | (base_p1 & ~mask_p1);

    // ---- stage 2: result register, flags travel with the packed field ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            instr_p2 <= '0;
            range_p2 <= 1'b0;
            align_p2 <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (IN_READY) begin
                vld_p1 <= IN_VALID;
            end
            if (adv_p1) begin
                vld_p2 <= vld_p1;
            end
            if (adv_p1 && vld_p1) begin
                instr_p2 <= merged_p1;
                range_p2 <= range_p1;
                align_p2 <= align_p1;
            end
            if (vld_p2 && OUT_READY && (range_p2 || align_p2)) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    assign OUT_VALID = vld_p2;
    assign INSTR     = instr_p2;
    assign RANGE_ERR = range_p2;
    assign ALIGN_ERR = align_p2;
    assign ERR_CNT   = err_cnt;

endmodule

// File: tb/tb_imm_pack_unit.sv
// Directed and randomized checks of the immediate packer: formats, flags, handshake, reset, counter.
module tb_imm_pack_unit;

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;
    localparam logic [1:0] SRC_J = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [1:0]  immsrc;
    logic [24:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] instr;
    logic        range_err;
    logic        align_err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
    } req_t;
    req_t q[$];
    req_t r;

    int          n_sent, n_recv, cyc, occ, w, n;
    logic        held;
    logic [24:0] held_instr;
    logic [31:0] rv, m, dec;
    logic        er, ea;

    imm_pack_unit #(.CNT_W(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IMM       (imm),
        .IMMSRC    (immsrc),
        .BASE      (base),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .INSTR     (instr),
        .RANGE_ERR (range_err),
        .ALIGN_ERR (align_err),
        .ERR_CNT   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single request through an empty pipeline with OUT_READY held high.
    task automatic send(input string tag, input logic [1:0] s, input logic [31:0] v,
                        input logic [24:0] b, input logic [24:0] exp_instr,
                        input logic exp_range, input logic exp_align);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        immsrc    = s;
        imm       = v;
        base      = b;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, 32'(instr), 32'(exp_instr));
        check({tag, "_range"}, 32'(range_err), 32'(exp_range));
        check({tag, "_align"}, 32'(align_err), 32'(exp_align));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] decode(input logic [1:0] s, input logic [24:0] i);
        case (s)
            SRC_I:   return {{20{i[24]}}, i[24:13]};
            SRC_S:   return {{20{i[24]}}, i[24:18], i[4:0]};
            SRC_B:   return {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
            default: return {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
        endcase
    endfunction

    function automatic logic model_range(input logic [1:0] s, input logic [31:0] v);
        logic signed [31:0] x;
        x = $signed(v);
        case (s)
            SRC_I, SRC_S: return (x < -32'sd2048) || (x > 32'sd2047);
            SRC_B:        return (x < -32'sd4096) || (x > 32'sd4095);
            default:      return (x < -32'sd1048576) || (x > 32'sd1048575);
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        imm       = '0;
        immsrc    = SRC_I;
        base      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_range", 32'(range_err), 32'd0);
        check("rst_align", 32'(align_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        send("i_neg_min", SRC_I, 32'hFFFFF800, 25'h0, 25'h1000000, 1'b0, 1'b0);
        check("cnt_after_ok", 32'(err_cnt), 32'd0);
        send("b_fffe", SRC_B, 32'h00000FFE, 25'h0, 25'h0FC001F, 1'b0, 1'b0);
        send("j_two", SRC_J, 32'h00000002, 25'h0, 25'h0004000, 1'b0, 1'b0);
        send("i_range", SRC_I, 32'h00000800, 25'h0, 25'h1000000, 1'b1, 1'b0);
        check("cnt_one", 32'(err_cnt), 32'd1);
        send("b_align", SRC_B, 32'h00000003, 25'h0, 25'h0000002, 1'b0, 1'b1);
        check("cnt_two", 32'(err_cnt), 32'd2);
        send("s_base", SRC_S, 32'h000007FF, 25'h0001FE0, 25'h0FC1FFF, 1'b0, 1'b0);
        send("j_neg_min", SRC_J, 32'hFFF00000, 25'h1FFFFFF, 25'h100001F, 1'b0, 1'b0);
        send("j_range", SRC_J, 32'h00100000, 25'h0, 25'h1000000, 1'b1, 1'b0);
        check("cnt_three", 32'(err_cnt), 32'd3);
        send("b_neg_min", SRC_B, 32'hFFFFF000, 25'h1FFFFFF, 25'h103FFE0, 1'b0, 1'b0);

        // Back-to-back stream with a randomly stalling consumer.
        n_sent = 0; n_recv = 0; cyc = 0; held = 1'b0; held_instr = '0;
        while ((n_recv < 8) && (cyc < 200)) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (n_sent < 8);
            immsrc    = SRC_I;
            imm       = 32'(n_sent);
            base      = 25'(n_sent + 32'h100);
            #1;
            occ = n_sent - n_recv;
            check("b2b_in_ready", 32'(in_ready), 32'(!((occ == 2) && !out_ready)));
            if (held) check("b2b_stall_hold", 32'(instr), 32'(held_instr));
            held       = out_valid && !out_ready;
            held_instr = instr;
            if (out_valid && out_ready) begin
                check("b2b_order", 32'(instr), (32'(n_recv) << 13) | (32'(n_recv) + 32'h100));
                n_recv++;
            end
            if (in_valid && in_ready) n_sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("b2b_recv_count", 32'(n_recv), 32'd8);
        check("b2b_sent_count", 32'(n_sent), 32'd8);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_drained", 32'(out_valid), 32'd0);
        check("cnt_before_rst", 32'(err_cnt), 32'd3);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        immsrc    = SRC_I;
        imm       = 32'h00001000;
        base      = '0;
        @(posedge clk); #1;
        imm = 32'h00002000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        check("inflight_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("midrst_no_ghost", 32'(out_valid), 32'd0);
        end

        // Counter saturation with 300 erroneous results at full rate.
        in_valid = 1'b1;
        immsrc   = SRC_I;
        imm      = 32'h00000800;
        base     = '0;
        n = 0; cyc = 0;
        while (cyc < 310) begin
            check("err_cnt_track", 32'(err_cnt), (n > 255) ? 32'd255 : 32'(n));
            if (cyc == 300) in_valid = 1'b0;
            if (out_valid) n++;
            @(posedge clk); #1;
            cyc++;
        end
        check("sat_transfers", 32'(n), 32'd300);
        check("sat_value", 32'(err_cnt), 32'hFF);

        // Random round-trip: decode of INSTR must equal IMM whenever no flag is raised.
        q.delete();
        n_sent = 0; n_recv = 0; cyc = 0;
        out_ready = 1'b1;
        while ((n_recv < 10000) && (cyc < 10100)) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 32'd1, 32'd0);
                end else begin
                    r  = q.pop_front();
                    er = model_range(r.src, r.imm);
                    ea = ((r.src == SRC_B) || (r.src == SRC_J)) && r.imm[0];
                    check("rnd_range", 32'(range_err), 32'(er));
                    check("rnd_align", 32'(align_err), 32'(ea));
                    if (!er && !ea) begin
                        dec = decode(r.src, instr);
                        check("rnd_roundtrip", dec, r.imm);
                    end
                end
                n_recv++;
            end
            if (n_sent < 10000) begin
                w  = $urandom_range(8, 22);
                rv = $urandom;
                m  = 32'hFFFFFFFF << w;
                rv = rv[w] ? (rv | m) : (rv & ~m);
                if ($urandom_range(0, 1) == 1) rv[0] = 1'b0;
                r.src = 2'($urandom_range(0, 3));
                r.imm = rv;
                immsrc   = r.src;
                imm      = r.imm;
                base     = 25'($urandom);
                in_valid = 1'b1;
                #1;
                if (in_ready) begin
                    q.push_back(r);
                    n_sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_recv_count", 32'(n_recv), 32'd10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
